// File: rtl/bram_fwft_fifo_pkg.sv
// Shared types for the BRAM-backed first-word-fall-through FIFO.
package bram_fwft_fifo_pkg;

    // Registered error pulses, one cycle after the offending request.
    typedef struct packed {
        logic overflow;
        logic underflow;
    } err_pulse_t;

endpackage : bram_fwft_fifo_pkg

// File: rtl/bram_fwft_fifo_bram.sv
// Simple dual-port block RAM: port A writes, port B reads into a registered output
// that holds its value whenever enb is low.
module DualPortBram #(
    parameter int WID  = 32,
    parameter int SIZE = 256
) (
    input  logic                    clk,
    input  logic                    ena,
    input  logic                    wea,
    input  logic [$clog2(SIZE)-1:0] addra,
    input  logic [WID-1:0]          dina,
    input  logic                    enb,
    input  logic [$clog2(SIZE)-1:0] addrb,
    output logic [WID-1:0]          doutb
);

    // NOTE: storage arrays are never reset; a reset loop would stop the array mapping onto block RAM.
    logic [WID-1:0] mem [SIZE];

    always_ff @(posedge clk) begin
        if (ena && wea) begin
            mem[addra] <= dina;
        end
        if (enb) begin
            doutb <= mem[addrb];
        end
    end

endmodule : DualPortBram

// File: rtl/bram_fwft_fifo.sv
// FWFT FIFO controller: prefetches the head entry into the BRAM output register so
// pop_data is valid combinationally whenever empty is low.
module bram_fwft_fifo
    import bram_fwft_fifo_pkg::*;
#(
    parameter int WID   = 32,
    parameter int DEPTH = 256
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         push,
    input  logic [WID-1:0]               push_data,
    output logic                         full,
    input  logic                         pop,
    output logic [WID-1:0]               pop_data,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = AW + 1;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] bram_cnt;
    logic          head_vld;
    logic          head_vld_next;
    logic          push_acc;
    logic          pop_acc;
    logic          fetch;
    err_pulse_t    err;

    // The head entry lives in the BRAM output register, so it is counted on top of
    // the entries still sitting between rd_ptr and wr_ptr.
    assign bram_cnt = wr_ptr - rd_ptr;
    assign count    = CW'(bram_cnt) + CW'(head_vld);
    assign full     = (count == CW'(DEPTH));
    assign empty    = ~head_vld;

    assign push_acc = push & ~full;
    assign pop_acc  = pop & head_vld;
    assign fetch    = (bram_cnt != '0) & (~head_vld | pop_acc);

    // NOTE: every variable driven in always_comb gets a default first so no latch is inferred.
    always_comb begin
        head_vld_next = head_vld;
        if (fetch) begin
            head_vld_next = 1'b1;
        end else if (pop_acc) begin
            head_vld_next = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            head_vld <= 1'b0;
            err      <= '0;
        end else begin
            if (push_acc) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (fetch) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            head_vld      <= head_vld_next;
            err.overflow  <= push & full;
            err.underflow <= pop & ~head_vld;
        end
    end

    assign overflow  = err.overflow;
    assign underflow = err.underflow;

    DualPortBram #(
        .WID  (WID),
        .SIZE (DEPTH)
    ) u_bram (
        .clk   (clk),
        .ena   (push_acc),
        .wea   (push_acc),
        .addra (wr_ptr[AW-1:0]),
        .dina  (push_data),
        .enb   (fetch),
        .addrb (rd_ptr[AW-1:0]),
        .doutb (pop_data)
    );

endmodule : bram_fwft_fifo
